// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch family: FSM state encoding,
// a generic time snapshot layout and field-limit helpers.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        SW_IDLE  = 2'd0,
        SW_RUN   = 2'd1,
        SW_PAUSE = 2'd2
    } sw_state_t;

    // Last valid seconds value before the minute rolls over.
    localparam int unsigned SEC_MAX = 32'd59;

    // Wide time snapshot layout for consumers that handle several time bases.
    typedef struct packed {
        logic [15:0] min;
        logic [5:0]  sec;
        logic [15:0] sub;
    } sw_time_t;

    // True when a time field sits at its last value and must wrap on the next increment.
    function automatic logic is_last(input int unsigned value, input int unsigned last);
        return (value == last);
    endfunction

endpackage

// File: rtl/stopwatch_lap_tick_gen.sv
// Clock divider producing a one-cycle registered tick every DIV enabled cycles.
// The count holds while disabled so the tick phase survives a pause; clr
// restarts the phase from zero and suppresses any pending tick.
module tick_gen #(
    parameter int unsigned DIV = 32'd100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned   CW   = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 32'd1);

    logic [CW-1:0] count_r;
    logic          tick_r;

    // Divider count and registered tick: clear to zero, hold when disabled, wrap at DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
            tick_r  <= 1'b0;
        end else if (clr) begin
            count_r <= {CW{1'b0}};
            tick_r  <= 1'b0;
        end else if (en) begin
            if (count_r == LAST) begin
                count_r <= {CW{1'b0}};
                tick_r  <= 1'b1;
            end else begin
                count_r <= count_r + CW'(1);
                tick_r  <= 1'b0;
            end
        end else begin
            count_r <= count_r;
            tick_r  <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/stopwatch_lap.sv
// Stopwatch with start/stop, lap-hold and clear. Keeps a live mm:ss:sub time
// advanced by tick_gen, an optional frozen lap snapshot, and a sticky
// overflow flag set whenever the time wraps past its maximum.
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter  int unsigned CLK_HZ  = 32'd50_000_000,
    parameter  int unsigned TICK_HZ = 32'd100,
    parameter  int unsigned MIN_MAX = 32'd99,
    localparam int unsigned SW      = $clog2(TICK_HZ),
    localparam int unsigned MW      = $clog2(MIN_MAX + 32'd1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_stop,
    input  logic          lap,
    input  logic          clear,
    output logic          running,
    output logic          lap_hold,
    output logic          overflow,
    output logic [SW-1:0] disp_sub,
    output logic [5:0]    disp_sec,
    output logic [MW-1:0] disp_min
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;

    if ((CLK_HZ % TICK_HZ) != 32'd0) begin : g_div_check
        $error("stopwatch_lap: CLK_HZ must be an exact multiple of TICK_HZ");
    end

    sw_state_t     state_r;
    sw_state_t     state_nx_s;
    logic          tick_s;

    logic [SW-1:0] sub_r;
    logic [5:0]    sec_r;
    logic [MW-1:0] min_r;
    logic          overflow_r;

    logic [SW-1:0] sub_inc_s;
    logic [5:0]    sec_inc_s;
    logic [MW-1:0] min_inc_s;
    logic          wrap_s;

    logic [SW-1:0] lap_sub_r;
    logic [5:0]    lap_sec_r;
    logic [MW-1:0] lap_min_r;
    logic          lap_hold_r;

    // Divider runs only in RUN; clear restarts its phase.
    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_r == SW_RUN),
        .clr   (clear),
        .tick  (tick_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= SW_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state: clear dominates, then start_stop toggles run/pause.
    always_comb begin
        state_nx_s = state_r;
        if (clear) begin
            state_nx_s = SW_IDLE;
        end else if (start_stop) begin
            case (state_r)
                SW_IDLE:  state_nx_s = SW_RUN;
                SW_RUN:   state_nx_s = SW_PAUSE;
                SW_PAUSE: state_nx_s = SW_RUN;
                default:  state_nx_s = SW_IDLE;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Incremented live time with cascaded field carries and full-range wrap detection.
    always_comb begin
        sub_inc_s = sub_r;
        sec_inc_s = sec_r;
        min_inc_s = min_r;
        wrap_s    = 1'b0;
        if (is_last(32'(sub_r), TICK_HZ - 32'd1)) begin
            sub_inc_s = {SW{1'b0}};
            if (is_last(32'(sec_r), SEC_MAX)) begin
                sec_inc_s = 6'd0;
                if (is_last(32'(min_r), MIN_MAX)) begin
                    min_inc_s = {MW{1'b0}};
                    wrap_s    = 1'b1;
                end else begin
                    min_inc_s = min_r + MW'(1);
                end
            end else begin
                sec_inc_s = sec_r + 6'd1;
            end
        end else begin
            sub_inc_s = sub_r + SW'(1);
        end
    end

    // Live time and sticky overflow: clear zeroes everything, otherwise advance on tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_r      <= {SW{1'b0}};
            sec_r      <= 6'd0;
            min_r      <= {MW{1'b0}};
            overflow_r <= 1'b0;
        end else if (clear) begin
            sub_r      <= {SW{1'b0}};
            sec_r      <= 6'd0;
            min_r      <= {MW{1'b0}};
            overflow_r <= 1'b0;
        end else if (tick_s) begin
            sub_r      <= sub_inc_s;
            sec_r      <= sec_inc_s;
            min_r      <= min_inc_s;
            overflow_r <= overflow_r | wrap_s;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Lap snapshot: a lap pulse releases an active hold, or captures the pre-increment live time in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_sub_r  <= {SW{1'b0}};
            lap_sec_r  <= 6'd0;
            lap_min_r  <= {MW{1'b0}};
            lap_hold_r <= 1'b0;
        end else if (clear) begin
            lap_sub_r  <= {SW{1'b0}};
            lap_sec_r  <= 6'd0;
            lap_min_r  <= {MW{1'b0}};
            lap_hold_r <= 1'b0;
        end else if (lap && !start_stop) begin
            if (lap_hold_r) begin
                lap_hold_r <= 1'b0;
            end else if (state_r == SW_RUN) begin
                lap_sub_r  <= sub_r;
                lap_sec_r  <= sec_r;
                lap_min_r  <= min_r;
                lap_hold_r <= 1'b1;
            end else begin
                lap_hold_r <= lap_hold_r;
            end
        end else begin
            lap_hold_r <= lap_hold_r;
        end
    end

    // Display selects the frozen lap or the live time, straight from registers.
    always_comb begin
        if (lap_hold_r) begin
            disp_sub = lap_sub_r;
            disp_sec = lap_sec_r;
            disp_min = lap_min_r;
        end else begin
            disp_sub = sub_r;
            disp_sec = sec_r;
            disp_min = min_r;
        end
    end

    assign running  = (state_r == SW_RUN);
    assign lap_hold = lap_hold_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Scoreboard bench for stopwatch_lap. A reference model tracks elapsed
// sub-second ticks as a single integer and derives display fields by
// division; every stimulus cycle pushes the expected outputs and an
// independent monitor pops and compares them half a cycle later.
module tb_stopwatch_lap;

    localparam int unsigned CLK_HZ  = 200;
    localparam int unsigned TICK_HZ = 10;
    localparam int unsigned MIN_MAX = 1;
    localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
    localparam int unsigned PERIOD  = (MIN_MAX + 1) * 60 * TICK_HZ;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       start_stop = 1'b0;
    logic       lap        = 1'b0;
    logic       clear      = 1'b0;
    logic       running;
    logic       lap_hold;
    logic       overflow;
    logic [3:0] disp_sub;
    logic [5:0] disp_sec;
    logic [0:0] disp_min;

    stopwatch_lap #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .MIN_MAX (MIN_MAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .running    (running),
        .lap_hold   (lap_hold),
        .overflow   (overflow),
        .disp_sub   (disp_sub),
        .disp_sec   (disp_sec),
        .disp_min   (disp_min)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          run;
        bit          hold;
        bit          ovf;
        int unsigned sub;
        int unsigned sec;
        int unsigned min;
        string       name;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  mon_e;
    int    n_checks = 0;
    int    n_fail   = 0;
    string phase    = "reset";

    // Reference model: 0 idle, 1 run, 2 pause; time as a count of elapsed ticks.
    int          m_state;
    int unsigned m_ticks;
    int unsigned m_lap;
    int unsigned m_run_cycles;
    bit          m_hold;
    bit          m_ovf;
    bit          m_pend;

    function automatic void model_reset();
        m_state      = 0;
        m_ticks      = 0;
        m_lap        = 0;
        m_run_cycles = 0;
        m_hold       = 1'b0;
        m_ovf        = 1'b0;
        m_pend       = 1'b0;
    endfunction

    function automatic void model_step(input bit cl, input bit ss, input bit lp);
        bit inc;
        bit next_pend;
        inc       = m_pend;
        next_pend = 1'b0;
        if (cl) begin
            model_reset();
        end else begin
            if (lp && !ss) begin
                if (m_hold) begin
                    m_hold = 1'b0;
                end else if (m_state == 1) begin
                    m_lap  = m_ticks;
                    m_hold = 1'b1;
                end
            end
            if (inc) begin
                m_ticks = m_ticks + 1;
                if (m_ticks == PERIOD) begin
                    m_ticks = 0;
                    m_ovf   = 1'b1;
                end
            end
            if (m_state == 1) begin
                m_run_cycles = m_run_cycles + 1;
                if (m_run_cycles % DIV == 0) next_pend = 1'b1;
            end
            if (ss) m_state = (m_state == 1) ? 2 : 1;
            m_pend = next_pend;
        end
    endfunction

    function automatic void push_exp();
        exp_t        e;
        int unsigned t;
        t      = m_hold ? m_lap : m_ticks;
        e.run  = (m_state == 1);
        e.hold = m_hold;
        e.ovf  = m_ovf;
        e.sub  = t % TICK_HZ;
        e.sec  = (t / TICK_HZ) % 60;
        e.min  = t / (TICK_HZ * 60);
        e.name = phase;
        exp_q.push_back(e);
    endfunction

    // Monitor: compare DUT outputs against the oldest expectation, away from the active edge.
    always begin
        @(negedge clk or negedge rst_n);
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            if (running !== mon_e.run || lap_hold !== mon_e.hold || overflow !== mon_e.ovf ||
                disp_sub !== 4'(mon_e.sub) || disp_sec !== 6'(mon_e.sec) || disp_min !== 1'(mon_e.min)) begin
                n_fail++;
                $display("FAIL %s @%0t: got run=%0b hold=%0b ovf=%0b %0d:%0d:%0d, expected run=%0b hold=%0b ovf=%0b %0d:%0d:%0d",
                         mon_e.name, $time, running, lap_hold, overflow, disp_min, disp_sec, disp_sub,
                         mon_e.run, mon_e.hold, mon_e.ovf, mon_e.min, mon_e.sec, mon_e.sub);
            end
        end
    end

    // One clock of stimulus: drive pulses, advance the model on the edge, queue the expectation.
    task automatic step(input bit cl, input bit ss, input bit lp);
        clear      = cl;
        start_stop = ss;
        lap        = lp;
        @(posedge clk);
        model_step(cl, ss, lp);
        push_exp();
        #1;
        clear      = 1'b0;
        start_stop = 1'b0;
        lap        = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic timeout_fail(input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired (model ticks=%0d)", what, m_ticks);
    endtask

    // Run until the model says a tick is presented on the next edge.
    task automatic until_pending(input int lim);
        int cnt;
        cnt = 0;
        while (!m_pend && cnt < lim) begin
            step(1'b0, 1'b0, 1'b0);
            cnt++;
        end
        if (!m_pend) timeout_fail({phase, "_pending"});
    endtask

    task automatic until_ticks(input int unsigned target, input int lim);
        int cnt;
        cnt = 0;
        while (m_ticks != target && cnt < lim) begin
            step(1'b0, 1'b0, 1'b0);
            cnt++;
        end
        if (m_ticks != target) timeout_fail({phase, "_ticks"});
    endtask

    // Asynchronous reset between edges; outputs must drop before the next clock.
    task automatic do_reset();
        @(negedge clk);
        #2;
        model_reset();
        push_exp();
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk);
            push_exp();
            #1;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned r;
        model_reset();
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk);
            push_exp();
            #1;
        end
        rst_n = 1'b1;
        phase = "idle_after_reset";
        idle(5);

        phase = "first_tick";
        step(1'b0, 1'b1, 1'b0);
        idle(DIV * TICK_HZ + 2);

        phase = "pause_phase";
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(DIV * 3 + DIV / 2 - 1);
        step(1'b0, 1'b1, 1'b0);
        idle(DIV * 5);
        step(1'b0, 1'b1, 1'b0);
        idle(DIV + 5);

        phase = "lap_hold";
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        until_ticks(25, 30 * DIV);
        step(1'b0, 1'b0, 1'b1);
        idle(DIV * 20);
        step(1'b0, 1'b0, 1'b1);
        idle(DIV);

        phase = "lap_in_pause";
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        idle(DIV);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);

        phase = "tick_coincide";
        until_pending(DIV + 2);
        step(1'b0, 1'b1, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 1'b0);
        until_pending(DIV + 2);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        until_pending(DIV + 2);
        step(1'b1, 1'b1, 1'b1);
        idle(DIV + 3);

        phase = "reset_mid_run";
        step(1'b0, 1'b1, 1'b0);
        until_ticks(34, 40 * DIV);
        do_reset();
        idle(DIV + 5);

        phase = "overflow";
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        until_ticks(PERIOD - 1, PERIOD * DIV + 10);
        until_ticks(0, DIV + 2);
        idle(DIV * 3);
        step(1'b1, 1'b0, 1'b0);
        idle(5);

        phase = "random";
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 999);
            step(r < 3, (r >= 3 && r < 12) || r == 0, (r >= 12 && r < 25) || r == 1);
        end

        @(negedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
